// File: rtl/tcs34725_pkg.sv
// Shared definitions for the TCS34725 bus-level emulation: register map, command
// byte encodings, default identity and the responder state type.
package tcs34725_pkg;

    localparam logic [6:0] DefaultDeviceAddr = 7'h29;
    localparam logic [7:0] DefaultIdValue    = 8'h44;

    localparam logic [4:0] RegEnable = 5'h00;
    localparam logic [4:0] RegAtime  = 5'h01;
    localparam logic [4:0] RegId     = 5'h12;
    localparam logic [4:0] RegStatus = 5'h13;
    localparam logic [4:0] RegCdatal = 5'h14;
    localparam logic [4:0] RegCdatah = 5'h15;
    localparam logic [4:0] RegRdatal = 5'h16;
    localparam logic [4:0] RegRdatah = 5'h17;
    localparam logic [4:0] RegGdatal = 5'h18;
    localparam logic [4:0] RegGdatah = 5'h19;
    localparam logic [4:0] RegBdatal = 5'h1A;
    localparam logic [4:0] RegBdatah = 5'h1B;

    localparam int unsigned CmdBit = 7;
    localparam logic [1:0] CmdTypeFixed   = 2'b00;
    localparam logic [1:0] CmdTypeAuto    = 2'b01;
    localparam logic [1:0] CmdTypeSpecial = 2'b11;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StCmd,
        StCmdAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck
    } resp_state_e;

    // Byte offset of a colour-data address from CDATAL; bit 0 selects the high byte.
    function automatic logic [2:0] data_index(input logic [4:0] addr);
        logic [4:0] off;
        off = addr - RegCdatal;
        return off[2:0];
    endfunction

    function automatic logic is_low_byte(input logic [4:0] addr);
        return (addr == RegCdatal) || (addr == RegRdatal) ||
               (addr == RegGdatal) || (addr == RegBdatal);
    endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes raw SCL/SDA pad levels and derives single-cycle SCL edge and
// START/STOP strobes from the synchronized signals.
module i2c_bus_monitor #(
    parameter int unsigned SyncStages = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SyncStages-1:0] scl_sync_q, scl_sync_d;
    logic [SyncStages-1:0] sda_sync_q, sda_sync_d;
    logic                  scl_prev_q, scl_prev_d;
    logic                  sda_prev_q, sda_prev_d;
    logic                  scl_level;

    assign scl_level = scl_sync_q[SyncStages-1];
    assign sda_level = sda_sync_q[SyncStages-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SyncStages-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SyncStages-2:0], sda_in};
        scl_prev_d = scl_level;
        sda_prev_d = sda_level;
    end

    // Idle bus is high on both lines, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_rise = scl_level & ~scl_prev_q;
    assign scl_fall = ~scl_level & scl_prev_q;
    assign start    = scl_level & scl_prev_q & sda_prev_q & ~sda_level;
    assign stop     = scl_level & scl_prev_q & ~sda_prev_q & sda_level;

endmodule

// File: rtl/tcs34725_i2c_responder.sv
// I2C target emulating a TCS34725 colour sensor register file at the bus level.
// Define TCS_RESPONDER_SHADOW_EN to make 16-bit low/high channel reads coherent.
module tcs34725_i2c_responder
    import tcs34725_pkg::*;
#(
    parameter logic [6:0]  DEVICE_ADDR = DefaultDeviceAddr,
    parameter logic [7:0]  ID_VALUE    = DefaultIdValue,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic        sample_valid,
    input  logic [15:0] clear_in,
    input  logic [15:0] red_in,
    input  logic [15:0] green_in,
    input  logic [15:0] blue_in,
    output logic [7:0]  enable_reg,
    output logic [7:0]  atime_reg,
    output logic        busy,
    output logic        cmd_error
);

    logic sda_level, scl_rise, scl_fall, bus_start, bus_stop;

    i2c_bus_monitor #(
        .SyncStages(SYNC_STAGES)
    ) u_bus_monitor (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_level(sda_level),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (bus_start),
        .stop     (bus_stop)
    );

    resp_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [4:0]        ptr_q, ptr_d;
    logic              auto_inc_q, auto_inc_d;
    logic [7:0]        enable_q, enable_d;
    logic [7:0]        atime_q, atime_d;
    logic              avalid_q, avalid_d;
    logic [3:0][15:0]  chan_q, chan_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic              cmd_error_q, cmd_error_d;
    logic              mack_q, mack_d;
`ifdef TCS_RESPONDER_SHADOW_EN
    logic [7:0]        shadow_q, shadow_d;
    logic [4:0]        shadow_ptr_q, shadow_ptr_d;
    logic              shadow_vld_q, shadow_vld_d;
`endif

    logic [7:0] rx_byte, rd_byte, chan_lo, chan_hi;
    logic [2:0] rd_idx;
    logic       bit_in, byte_done, wr_en, load_rd;

    assign rx_byte   = {shift_q[6:0], sda_level};
    assign bit_in    = scl_rise && (cnt_q < 4'd8);
    assign byte_done = scl_fall && (cnt_q == 4'd8);

    // Byte presented to the master for the current pointer.
    always_comb begin
        rd_idx  = data_index(ptr_q);
        chan_lo = chan_q[rd_idx[2:1]][7:0];
        chan_hi = chan_q[rd_idx[2:1]][15:8];
        rd_byte = 8'h00;
        if (ptr_q == RegEnable) begin
            rd_byte = enable_q;
        end else if (ptr_q == RegAtime) begin
            rd_byte = atime_q;
        end else if (ptr_q == RegId) begin
            rd_byte = ID_VALUE;
        end else if (ptr_q == RegStatus) begin
            rd_byte = {7'b0, avalid_q};
        end else if (ptr_q >= RegCdatal && ptr_q <= RegBdatah) begin
            if (!rd_idx[0]) begin
                rd_byte = chan_lo;
            end else begin
`ifdef TCS_RESPONDER_SHADOW_EN
                rd_byte = (shadow_vld_q && ptr_q == shadow_ptr_q) ? shadow_q : chan_hi;
`else
                rd_byte = chan_hi;
`endif
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        auto_inc_d  = auto_inc_q;
        enable_d    = enable_q;
        atime_d     = atime_q;
        avalid_d    = avalid_q;
        chan_d      = chan_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        cmd_error_d = 1'b0;
        mack_d      = mack_q;
`ifdef TCS_RESPONDER_SHADOW_EN
        shadow_d     = shadow_q;
        shadow_ptr_d = shadow_ptr_q;
        shadow_vld_d = shadow_vld_q;
`endif
        wr_en   = 1'b0;
        load_rd = 1'b0;

        if (sample_valid && enable_q[1:0] == 2'b11) begin
            chan_d[0] = clear_in;
            chan_d[1] = red_in;
            chan_d[2] = green_in;
            chan_d[3] = blue_in;
            avalid_d  = 1'b1;
        end

        if (bus_stop) begin
            state_d  = StIdle;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
        end else if (bus_start) begin
            state_d  = StAddr;
            cnt_d    = 4'd0;
            busy_d   = 1'b1;
            sda_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                StAddr: begin
                    if (bit_in) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (byte_done) begin
                        if (shift_q[7:1] == DEVICE_ADDR) begin
                            sda_oe_d = 1'b1;
                            state_d  = StAddrAck;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        if (shift_q[0]) begin
                            load_rd = 1'b1;
                            state_d = StRdata;
                        end else begin
                            state_d = StCmd;
                        end
                    end
                end
                StCmd: begin
                    if (bit_in) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (byte_done) begin
                        if (!shift_q[CmdBit]) begin
                            cmd_error_d = 1'b1;
                            state_d     = StIdle;
                        end else begin
                            sda_oe_d = 1'b1;
                            state_d  = StCmdAck;
                            // Special-function types leave the pointer mode untouched.
                            if (shift_q[6:5] == CmdTypeFixed || shift_q[6:5] == CmdTypeAuto) begin
                                ptr_d      = shift_q[4:0];
                                auto_inc_d = (shift_q[6:5] == CmdTypeAuto);
                            end
                        end
                    end
                end
                StCmdAck, StWdataAck: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = StWdata;
                    end
                end
                StWdata: begin
                    if (bit_in) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        wr_en   = (cnt_q == 4'd7);
                    end else if (byte_done) begin
                        sda_oe_d = 1'b1;
                        state_d  = StWdataAck;
                    end
                end
                StRdata: begin
                    if (bit_in) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (byte_done) begin
                        sda_oe_d = 1'b0;
                        state_d  = StRdataAck;
                    end else if (scl_fall && cnt_q != 4'd0) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                StRdataAck: begin
                    if (scl_rise) begin
                        mack_d = ~sda_level;
                    end else if (scl_fall) begin
                        if (mack_q) begin
                            load_rd = 1'b1;
                            state_d = StRdata;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = StIdle;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (wr_en) begin
            if (ptr_q == RegEnable) begin
                enable_d = rx_byte;
                if (!rx_byte[1]) avalid_d = 1'b0;
            end else if (ptr_q == RegAtime) begin
                atime_d = rx_byte;
            end
            if (auto_inc_q) ptr_d = ptr_q + 5'd1;
        end

        if (load_rd) begin
            shift_d  = rd_byte;
            sda_oe_d = ~rd_byte[7];
            cnt_d    = 4'd0;
            if (auto_inc_q) ptr_d = ptr_q + 5'd1;
`ifdef TCS_RESPONDER_SHADOW_EN
            if (is_low_byte(ptr_q)) begin
                shadow_d     = chan_hi;
                shadow_ptr_d = ptr_q + 5'd1;
                shadow_vld_d = 1'b1;
            end else if (ptr_q == shadow_ptr_q) begin
                shadow_vld_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            shift_q     <= 8'h00;
            ptr_q       <= 5'd0;
            auto_inc_q  <= 1'b0;
            enable_q    <= 8'h00;
            atime_q     <= 8'hFF;
            avalid_q    <= 1'b0;
            chan_q      <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            cmd_error_q <= 1'b0;
            mack_q      <= 1'b0;
`ifdef TCS_RESPONDER_SHADOW_EN
            shadow_q     <= 8'h00;
            shadow_ptr_q <= 5'd0;
            shadow_vld_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            auto_inc_q  <= auto_inc_d;
            enable_q    <= enable_d;
            atime_q     <= atime_d;
            avalid_q    <= avalid_d;
            chan_q      <= chan_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            cmd_error_q <= cmd_error_d;
            mack_q      <= mack_d;
`ifdef TCS_RESPONDER_SHADOW_EN
            shadow_q     <= shadow_d;
            shadow_ptr_q <= shadow_ptr_d;
            shadow_vld_q <= shadow_vld_d;
`endif
        end
    end

    assign sda_oe     = sda_oe_q;
    assign busy       = busy_q;
    assign cmd_error  = cmd_error_q;
    assign enable_reg = enable_q;
    assign atime_reg  = atime_q;

endmodule
